// File: rtl/reg_file_if.sv
// Register-file port bundle: two read ports and one write port.
// master = decode/writeback side, slave = the register file.
interface reg_file_if #(
    parameter int unsigned XLEN = 32
);
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd;
    logic [XLEN-1:0] write_data;
    logic            wr_en;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    modport master (
        output rs1_addr,
        output rs2_addr,
        output rd,
        output write_data,
        output wr_en,
        input  rs1_data,
        input  rs2_data
    );

    modport slave (
        input  rs1_addr,
        input  rs2_addr,
        input  rd,
        input  write_data,
        input  wr_en,
        output rs1_data,
        output rs2_data
    );
endinterface

// File: rtl/reg_file.sv
// RV32I integer register file: 32 x XLEN, x0 hardwired to zero,
// two combinational read ports with same-cycle write-through bypass.
module reg_file #(
    parameter int unsigned XLEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    reg_file_if.slave  bus
);
    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];
    logic            bypass_en;

    always_comb begin
        regs_d = regs_q;
        if (bus.wr_en && (bus.rd != 5'd0)) begin
            regs_d[bus.rd] = bus.write_data;
        end
        regs_d[0] = '0;
    end

    // Reset wins over a write on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass is suppressed while reset is low so a dropped write never shows.
    assign bypass_en = bus.wr_en & reset;

    always_comb begin
        bus.rs1_data = regs_q[bus.rs1_addr];
        if (bus.rs1_addr == 5'd0) begin
            bus.rs1_data = '0;
        end else if (bypass_en && (bus.rd == bus.rs1_addr)) begin
            bus.rs1_data = bus.write_data;
        end
    end

    always_comb begin
        bus.rs2_data = regs_q[bus.rs2_addr];
        if (bus.rs2_addr == 5'd0) begin
            bus.rs2_data = '0;
        end else if (bypass_en && (bus.rd == bus.rs2_addr)) begin
            bus.rs2_data = bus.write_data;
        end
    end
endmodule

// File: tb/tb_reg_file.sv
// Directed table-driven bench for reg_file: each vector is driven after a
// falling edge and its read ports are compared before the next rising edge.
module tb_reg_file;
    localparam int unsigned XLEN = 32;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t vecs [28];

    reg_file_if #(.XLEN(XLEN)) bus ();

    reg_file #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] rd,
                                input logic [31:0] wd, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [31:0] e1,
                                input logic [31:0] e2);
        vec_t v;
        v.rst = rst; v.we = we; v.rd = rd; v.wd = wd;
        v.a1 = a1;   v.a2 = a2; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    // Pattern for the fill sequence, derived from the index alone.
    function automatic logic [31:0] fill_val(input int unsigned idx);
        logic [7:0] b;
        b = idx[7:0];
        return {b, 8'hA5, ~b, 8'h3C};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] rd,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        reset          = rst;
        bus.wr_en      = we;
        bus.rd         = rd;
        bus.write_data = wd;
        bus.rs1_addr   = a1;
        bus.rs2_addr   = a2;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //              rst we  rd  wd            a1  a2  exp rs1       exp rs2
        vecs[0]  = mk(1, 0, 0,  32'h0,        0,  31, 32'h0,        32'h0);
        vecs[1]  = mk(1, 0, 0,  32'h0,        5,  17, 32'h0,        32'h0);
        vecs[2]  = mk(1, 1, 5,  32'hDEADBEEF, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF);
        vecs[3]  = mk(0, 0, 0,  32'h0,        5,  1,  32'hDEADBEEF, 32'h0);
        vecs[4]  = mk(1, 0, 0,  32'h0,        5,  5,  32'h0,        32'h0);
        vecs[5]  = mk(1, 1, 1,  32'h1,        1,  2,  32'h1,        32'h0);
        vecs[6]  = mk(1, 1, 2,  32'h10,       1,  2,  32'h1,        32'h10);
        vecs[7]  = mk(1, 1, 3,  32'h100,      3,  1,  32'h100,      32'h1);
        vecs[8]  = mk(1, 1, 10, 32'h0,        10, 3,  32'h0,        32'h100);
        vecs[9]  = mk(1, 0, 2,  32'hFFFFFFFF, 2,  3,  32'h10,       32'h100);
        vecs[10] = mk(1, 0, 0,  32'h0,        3,  10, 32'h100,      32'h0);
        vecs[11] = mk(1, 0, 0,  32'h0,        10, 1,  32'h0,        32'h1);
        vecs[12] = mk(1, 1, 0,  32'hFFFFFFFF, 0,  0,  32'h0,        32'h0);
        vecs[13] = mk(1, 0, 0,  32'h0,        0,  0,  32'h0,        32'h0);
        vecs[14] = mk(1, 1, 7,  32'hA5A5A5A5, 7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5);
        vecs[15] = mk(1, 0, 0,  32'h0,        7,  7,  32'hA5A5A5A5, 32'hA5A5A5A5);
        vecs[16] = mk(1, 1, 4,  32'h12345678, 4,  7,  32'h12345678, 32'hA5A5A5A5);
        vecs[17] = mk(1, 0, 4,  32'h0,        4,  4,  32'h12345678, 32'h12345678);
        vecs[18] = mk(1, 0, 4,  32'h0,        4,  4,  32'h12345678, 32'h12345678);
        vecs[19] = mk(1, 0, 4,  32'h0,        4,  4,  32'h12345678, 32'h12345678);
        vecs[20] = mk(1, 1, 9,  32'h77,       9,  4,  32'h77,       32'h12345678);
        vecs[21] = mk(0, 1, 9,  32'h55,       9,  4,  32'h77,       32'h12345678);
        vecs[22] = mk(1, 0, 0,  32'h0,        9,  4,  32'h0,        32'h0);
        vecs[23] = mk(1, 1, 12, 32'h11,       12, 0,  32'h11,       32'h0);
        vecs[24] = mk(1, 1, 12, 32'h22,       12, 12, 32'h22,       32'h22);
        vecs[25] = mk(1, 0, 0,  32'h0,        12, 9,  32'h22,       32'h0);
        vecs[26] = mk(1, 1, 31, 32'h80000001, 31, 30, 32'h80000001, 32'h0);
        vecs[27] = mk(1, 0, 0,  32'h0,        31, 31, 32'h80000001, 32'h80000001);

        reset          = 1'b0;
        bus.wr_en      = 1'b0;
        bus.rd         = '0;
        bus.write_data = '0;
        bus.rs1_addr   = '0;
        bus.rs2_addr   = '0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].a1, vecs[i].a2);
            check($sformatf("vec%0d rs1", i), bus.rs1_data, vecs[i].e1);
            check($sformatf("vec%0d rs2", i), bus.rs2_data, vecs[i].e2);
        end

        // Fill every register, read all back on both ports, then reset once
        // and confirm the whole file is cleared.
        for (int unsigned r = 0; r < 32; r++) begin
            drive(1'b1, 1'b1, 5'(r), fill_val(r), 5'd0, 5'd0);
        end
        for (int unsigned r = 0; r < 32; r++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(r), 5'(31 - r));
            check($sformatf("fill x%0d rs1", r), bus.rs1_data, (r == 0) ? 32'h0 : fill_val(r));
            check($sformatf("fill x%0d rs2", 31 - r), bus.rs2_data,
                  (r == 31) ? 32'h0 : fill_val(31 - r));
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int unsigned r = 0; r < 32; r++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(r), 5'(r));
            check($sformatf("clr x%0d rs1", r), bus.rs1_data, 32'h0);
            check($sformatf("clr x%0d rs2", r), bus.rs2_data, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_file.md
# reg_file

Integer register file for the 32-register RV32I core (module `reg_file`). It provides two combinational read ports (rs1, rs2) and one synchronous write port (rd). It sits between the decode stage, which reads operands, and the writeback stage, which writes results. Register x0 is hardwired to zero, and a same-cycle write is forwarded to the read ports.

## Interface
- `XLEN`, default 32: data width of each register and of the data ports.
- Register count fixed at 32 (5-bit addresses); not a parameter.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-low reset; sampled on rising `clk`.
- `rs1_addr` input 5: read port 1 register index.
- `rs2_addr` input 5: read port 2 register index.
- `rd` input 5: write port destination index.
- `write_data` input XLEN: data to write.
- `wr_en` input 1: write enable, active-high.
- `rs1_data` output XLEN: contents of register `rs1_addr`.
- `rs2_data` output XLEN: contents of register `rs2_addr`.

## Operation
- Storage is 32 × XLEN registers, x0..x31.
- **Reset:** when `reset`==0 at a rising edge, all 32 registers are cleared to 0. Reset has priority over any write in the same cycle.
- **Write:**
  - Occurs at a rising edge when `reset`==1, `wr_en`==1 and `rd`!=0: register[`rd`] <= `write_data`.
  - Writes to x0 are silently discarded; x0 always reads 0.
  - `wr_en`==0 leaves all registers unchanged, whatever `rd` and `write_data` hold.
- **Read (each port independent, purely combinational):**
  - Address 0 returns 0.
  - Otherwise, if `wr_en`==1, `reset`==1 and `rd`== the port address, the port returns `write_data` (write-through bypass, so writeback is visible in the same cycle to decode).
  - Otherwise the port returns the stored register[address].
- Both ports may read the same register, including the one being written; both get the same value.
- No X propagation from storage after reset: every register holds a defined value.

## Timing
- Write latency: 1 cycle. The value is stored at the rising edge where `wr_en` is sampled high, and is visible from stored state immediately after that edge.
- Read latency: 0 cycles (combinational from `rs*_addr`, and through the bypass from `rd`/`wr_en`/`write_data`).
- During the cycle in which `reset`==0:
  - the bypass is disabled;
  - outputs reflect stored contents, which may be pre-reset values until the reset edge;
  - from the edge onward, all reads return 0 until a new write.
- Reset asserted in the middle of a write sequence: the write at that edge is dropped; the register is 0 afterwards.
- Back-to-back writes to the same register on consecutive edges: the last one wins.
- No handshake; every cycle is independent.

## Test plan
- **Reset clears:**
  - Preload x5=0xDEADBEEF.
  - Hold `reset`=0 for one rising edge.
  - Required: x5 and every other register read 0x00000000 on both ports.
- **Basic write/read:**
  - Write x1=0x00000001, x2=0x00000010, x3=0x00000100 (one per edge, `wr_en`=1).
  - Then `wr_en`=0 and read each through rs1 and through rs2.
  - Required: exact values returned; x10 written with 0x00000000 reads 0.
- **x0 hardwired:**
  - Write x0=0xFFFFFFFF.
  - Required: `rs1_data`=`rs2_data`=0 when addressing x0, including during the write cycle (no bypass).
- **Write-through bypass:**
  - In one cycle, `rd`=7, `write_data`=0xA5A5A5A5, `wr_en`=1, `rs1_addr`=7, `rs2_addr`=7.
  - Required: both outputs show 0xA5A5A5A5 before the edge; x7 still holds 0xA5A5A5A5 after the edge.
- **Write disabled:**
  - After x4=0x12345678, drive `rd`=4, `write_data`=0x0, `wr_en`=0 for several edges.
  - Required: x4 reads 0x12345678.
- **Reset priority:**
  - Same edge: `reset`=0, `wr_en`=1, `rd`=9, `write_data`=0x55.
  - Required: x9 reads 0 after the edge; the bypass does not show 0x55 during that cycle.
